// File: rtl/card_dealer_if.sv
// Controller <-> card_dealer bundle: load strobes in, card registers and scores out.
interface card_dealer_if;
  logic       new_hand;
  logic       load_pcard1, load_pcard2, load_pcard3;
  logic       load_dcard1, load_dcard2, load_dcard3;
  logic [3:0] pcard1, pcard2, pcard3;
  logic [3:0] dcard1, dcard2, dcard3;
  logic [3:0] pscore, dscore;
  logic [5:0] cards_left;
  logic       deck_empty;
  logic       deal_error;

  modport master (
    output new_hand, load_pcard1, load_pcard2, load_pcard3,
           load_dcard1, load_dcard2, load_dcard3,
    input  pcard1, pcard2, pcard3, dcard1, dcard2, dcard3,
           pscore, dscore, cards_left, deck_empty, deal_error
  );

  modport slave (
    input  new_hand, load_pcard1, load_pcard2, load_pcard3,
           load_dcard1, load_dcard2, load_dcard3,
    output pcard1, pcard2, pcard3, dcard1, dcard2, dcard3,
           pscore, dscore, cards_left, deck_empty, deal_error
  );
endinterface

// File: rtl/card_dealer.sv
// Baccarat card dealer: 52-card shoe with LFSR-seeded circular pick, six card
// registers (P1..P3, D1..D3) and combinational hand scores.
module card_dealer #(
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic         slow_clock,
  input  logic         resetb,
  card_dealer_if.slave bus
);

  logic [5:0][3:0] card_q, card_d;   // slot 0..5 = P1,P2,P3,D1,D2,D3
  logic [51:0]     used_q, used_d;
  logic [5:0]      left_q, left_d;
  logic [7:0]      lfsr_q, lfsr_d;
  logic            err_q,  err_d;

  logic [5:0] load;
  logic [2:0] sel;
  logic [5:0] start;
  logic [5:0] pick;
  logic [6:0] probe;
  logic       found;
  logic [3:0] rank;

  assign load  = {bus.load_dcard3, bus.load_dcard2, bus.load_dcard1,
                  bus.load_pcard3, bus.load_pcard2, bus.load_pcard1};
  assign start = (lfsr_q[5:0] < 6'd52) ? lfsr_q[5:0] : lfsr_q[5:0] - 6'd52;
  assign rank  = 4'(pick % 6'd13) + 4'd1;

  // Lowest set strobe wins (P1 highest priority).
  always_comb begin
    sel = '0;
    for (int i = 5; i >= 0; i--)
      if (load[i]) sel = 3'(i);
  end

  // First undealt index scanning start, start+1, ..., wrapping past 51.
  always_comb begin
    pick  = start;
    found = 1'b0;
    probe = '0;
    for (int k = 0; k < 52; k++) begin
      probe = {1'b0, start} + 7'(k);
      if (probe >= 7'd52) probe = probe - 7'd52;
      if (!found && !used_q[probe[5:0]]) begin
        found = 1'b1;
        pick  = probe[5:0];
      end
    end
  end

  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    card_d = card_q;
    used_d = used_q;
    left_d = left_q;
    err_d  = 1'b0;
    if (bus.new_hand) begin
      card_d = '0;
    end else if (|load) begin
      if (left_q != 6'd0) begin
        card_d[sel]  = rank;
        used_d[pick] = 1'b1;
        left_d       = left_q - 6'd1;
      end else begin
        card_d[sel] = 4'd0;
        err_d       = 1'b1;
      end
    end
  end

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      card_q <= '0;
      used_q <= '0;
      left_q <= 6'd52;
      lfsr_q <= LFSR_SEED;
      err_q  <= 1'b0;
    end else begin
      card_q <= card_d;
      used_q <= used_d;
      left_q <= left_d;
      lfsr_q <= lfsr_d;
      err_q  <= err_d;
    end
  end

  function automatic logic [4:0] cval(input logic [3:0] c);
    return (c >= 4'd10) ? 5'd0 : {1'b0, c};
  endfunction

  function automatic logic [3:0] hand(input logic [3:0] a, input logic [3:0] b,
                                      input logic [3:0] c);
    logic [4:0] t;
    t = cval(a) + cval(b) + cval(c);
    return 4'(t % 5'd10);
  endfunction

  assign bus.pcard1     = card_q[0];
  assign bus.pcard2     = card_q[1];
  assign bus.pcard3     = card_q[2];
  assign bus.dcard1     = card_q[3];
  assign bus.dcard2     = card_q[4];
  assign bus.dcard3     = card_q[5];
  assign bus.pscore     = hand(card_q[0], card_q[1], card_q[2]);
  assign bus.dscore     = hand(card_q[3], card_q[4], card_q[5]);
  assign bus.cards_left = left_q;
  assign bus.deck_empty = (left_q == 6'd0);
  assign bus.deal_error = err_q;

endmodule

// File: doc/card_dealer.md
# card_dealer

Responder to the baccarat round controller's load strobes: holds a 52-card shoe, deals one pseudo-random undealt card per load request into the addressed player/dealer card register, and presents the two hand scores back to the controller. Sits between the controller and the seven-segment/score display path. Card ranks are 1..13 (A..K). The shoe persists across hands until reset.

## Interface
Parameters:
- LFSR_SEED, 8'hA5, non-zero LFSR value loaded on reset.

Ports:
- slow_clock  input  1  single clock; all state updates on its rising edge.
- resetb  input  1  asynchronous, active-low reset.
- new_hand  input  1  synchronous; clears all six card registers, keeps shoe state.
- load_pcard1, load_pcard2, load_pcard3  input  1 each  deal one card into player slot 1/2/3.
- load_dcard1, load_dcard2, load_dcard3  input  1 each  deal one card into dealer slot 1/2/3.
- pcard1, pcard2, pcard3, dcard1, dcard2, dcard3  output  4 each  registered card ranks; 0 = empty slot.
- pscore, dscore  output  4 each  combinational hand scores, 0..9.
- cards_left  output  6  undealt cards remaining, 0..52.
- deck_empty  output  1  high when cards_left == 0.
- deal_error  output  1  registered; high for one cycle after a load request while shoe was empty.

## Operation
- Shoe: 52-bit used map, bit i = card index i dealt; rank(i) = (i mod 13) + 1.
- LFSR: 8-bit Fibonacci, shifts left every rising edge unconditionally; next = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
- Start index s = lfsr[5:0] if < 52, else lfsr[5:0] - 52 (uses LFSR value before the shift on that edge).
- Pick: first index j with used[j]==0 scanning s, s+1, ..., 51, 0, ..., s-1 (circular priority search, combinational).
- On an edge with a load request and cards_left > 0: selected slot <= rank(j); used[j] <= 1; cards_left decrements by 1.
- On an edge with a load request and cards_left == 0: slot <= 0, used/cards_left unchanged, deal_error <= 1 for that cycle.
- Multiple load strobes same edge: only highest priority served (pcard1 > pcard2 > pcard3 > dcard1 > dcard2 > dcard3); others ignored, no card consumed for them.
- Loading an already filled slot overwrites it and consumes a new card.
- new_hand on same edge as a load: new_hand wins, load ignored, no card consumed.
- Card value: rank 1..9 -> rank, 10..13 -> 0. Score = (v1 + v2 + v3) mod 10, 5-bit intermediate sum (max 27); empty slot contributes 0.
- Reset (resetb low, immediate): all card registers 0, used map all 0, cards_left 52, lfsr <= LFSR_SEED, deal_error 0. Hence pscore = dscore = 0, deck_empty = 0. Reset mid-hand discards the hand and refills the shoe.

## Timing
- Controller changes strobes on falling edge; this block samples on rising edge, so strobes are stable half a period before use.
- Latency: card register, used map, cards_left valid 1 cycle after the sampling edge; pscore/dscore follow combinationally in the same cycle.
- deal_error: asserted the cycle after the failing request, cleared on the next edge with no failing request.
- deck_empty: combinational from cards_left; goes high the cycle after the 52nd card is dealt.
- No stall, no handshake acknowledge: every served request completes in one edge.

## Test plan
- Reset, one load_pcard1 edge -> lfsr A5, s = 37, pcard1 = 12, pscore = 0, cards_left = 51; next start from lfsr 4A -> s = 10.
- Deal P1 = 7, P2 = 8 (force used map/LFSR via directed sequence from seed) -> pscore = 5; add pcard3 = 9 -> pscore = 4 (24 mod 10).
- 52 consecutive single loads cycling slots, new_hand every 6 -> every index dealt exactly once, cards_left 0, deck_empty 1; 53rd load -> slot 0, deal_error 1 one cycle, cards_left stays 0.
- load_pcard2 and load_dcard1 same edge -> only pcard2 written, cards_left drops by 1; new_hand + load_dcard2 same edge -> all slots 0, cards_left unchanged.
- resetb pulsed low between edges after 10 deals -> outputs 0, cards_left 52 immediately, no edge required; next deal reproduces first-deal value 12.
- Overwrite: two loads to dcard1 -> dcard1 holds second rank, cards_left decreased by 2, dscore reflects only the second card.
